// File: rtl/marlann_qpi_pkg.sv
// Shared definitions for the marlann QPI target front-end:
// command codes, FSM state encoding and the header-length table.
package marlann_qpi_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h20;
  localparam logic [7:0] CMD_WRBUF  = 8'h21;
  localparam logic [7:0] CMD_RDBUF  = 8'h22;
  localparam logic [7:0] CMD_STORE  = 8'h23;
  localparam logic [7:0] CMD_LOAD   = 8'h24;
  localparam logic [7:0] CMD_RUN    = 8'h25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_HDR,
    ST_WAIT,
    ST_TX,
    ST_SKIP
  } state_t;

  // len counts the command byte itself.
  typedef struct packed {
    logic       known;
    logic       in_only;
    logic [2:0] len;
  } hlen_t;

  function automatic hlen_t hlen(input logic [7:0] cmd);
    hlen_t h;
    h = '0;
    case (cmd)
      CMD_STATUS, CMD_RDBUF: begin
        h.known = 1'b1;
        h.len   = 3'd1;
      end
      CMD_STORE, CMD_LOAD: begin
        h.known = 1'b1;
        h.len   = 3'd4;
      end
      CMD_WRBUF, CMD_RUN: begin
        h.known   = 1'b1;
        h.in_only = 1'b1;
      end
      default: h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/marlann_qpi_sync.sv
// Synchroniser for qpi_csb/qpi_clk/qpi_io with registered posedge detect.
// Ports: clock, reset in; qpi_csb, qpi_clk, qpi_io_in async in;
//   csb_s, clk_pos (1-cycle), io_s[3:0] out, all mutually aligned.
// QPI_GLITCH_FILTER_EN: clk edge needs 2 equal synced samples (+1 clock).
module marlann_qpi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_in,
  output logic       csb_s,
  output logic       clk_pos,
  output logic [3:0] io_s
);

  logic [SYNC_STAGES-1:0][5:0] r_q;
  logic [5:0] w_last;
  logic       r_csb;
  logic       r_pos;
  logic [3:0] r_io;

  assign w_last = r_q[SYNC_STAGES-1];

  // Chain resets to csb=0 so a frame in progress at reset is not
  // mistaken for a new one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= {r_q[SYNC_STAGES-2:0],
                       {qpi_csb, qpi_clk, qpi_io_in}};
  end

`ifdef QPI_GLITCH_FILTER_EN
  logic [5:0] r_d1;
  logic       r_lvl;
  logic       w_stable;

  assign w_stable = (w_last[4] == r_d1[4]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d1  <= '0;
      r_lvl <= 1'b0;
      r_pos <= 1'b0;
      r_csb <= 1'b0;
      r_io  <= '0;
    end else begin
      r_d1  <= w_last;
      if (w_stable) r_lvl <= w_last[4];
      r_pos <= w_stable & w_last[4] & ~r_lvl;
      r_csb <= r_d1[5];
      r_io  <= r_d1[3:0];
    end
  end
`else
  logic r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_pos  <= 1'b0;
      r_csb  <= 1'b0;
      r_io   <= '0;
    end else begin
      r_prev <= w_last[4];
      r_pos  <= w_last[4] & ~r_prev;
      r_csb  <= w_last[5];
      r_io   <= w_last[3:0];
    end
  end
`endif

  assign csb_s   = r_csb;
  assign clk_pos = r_pos;
  assign io_s    = r_io;

endmodule

// File: rtl/marlann_qpi_target.sv
// QPI target framing: nibble deserialiser, command/header/wait/tx FSM.
// Ports: clock, reset; qpi_csb/qpi_clk/qpi_io_in pads in, qpi_io_out/oe
//   out; rx_valid/rx_data/rx_first/frame_end out; tx_valid/tx_data in,
//   tx_ready out; qpi_err sticky out, err_clear in.
// QPI_GLITCH_FILTER_EN (in marlann_qpi_sync) adds clk glitch rejection.
module marlann_qpi_target
  import marlann_qpi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_in,
  output logic [3:0] qpi_io_out,
  output logic       qpi_io_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       frame_end,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       qpi_err,
  input  logic       err_clear
);

  logic       w_csb, w_pos;
  logic [3:0] w_io;

  marlann_qpi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .qpi_csb   (qpi_csb),
    .qpi_clk   (qpi_clk),
    .qpi_io_in (qpi_io_in),
    .csb_s     (w_csb),
    .clk_pos   (w_pos),
    .io_s      (w_io)
  );

  state_t     r_state, w_state_nx;
  logic       r_nib, w_nib_nx;
  logic [3:0] r_hi, w_hi_nx;
  logic [3:0] r_lo, w_lo_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic       r_inonly, w_inonly_nx;
  logic       r_oe, w_oe_nx;
  logic [3:0] r_out, w_out_nx;
  logic       w_rx_v, w_rx_first, w_err_set, w_tx_rdy, w_launch;
  logic [7:0] w_byte;
  hlen_t      w_h;
  logic       r_armed, r_csb_prev;
  logic       r_rx_valid, r_rx_first, r_frame_end, r_tx_ready, r_err;
  logic [7:0] r_rx_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // r_nib: rx states = high nibble held; ST_TX = low nibble pending.
  always_comb begin
    w_state_nx  = r_state;
    w_nib_nx    = r_nib;
    w_hi_nx     = r_hi;
    w_lo_nx     = r_lo;
    w_cnt_nx    = r_cnt;
    w_inonly_nx = r_inonly;
    w_oe_nx     = r_oe;
    w_out_nx    = r_out;
    w_rx_v      = 1'b0;
    w_rx_first  = 1'b0;
    w_err_set   = 1'b0;
    w_tx_rdy    = 1'b0;
    w_launch    = 1'b0;
    w_byte      = {r_hi, w_io};
    w_h         = hlen(w_byte);
    if (w_csb) begin
      w_state_nx = ST_IDLE;
      w_nib_nx   = 1'b0;
      w_oe_nx    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (r_armed) begin
          w_state_nx = ST_CMD;
          w_nib_nx   = 1'b0;
        end
        ST_CMD, ST_HDR: if (w_pos) begin
          w_nib_nx = ~r_nib;
          if (!r_nib) begin
            w_hi_nx = w_io;
          end else if (r_state == ST_HDR) begin
            w_rx_v = 1'b1;
            if (!r_inonly) begin
              w_cnt_nx = r_cnt - 3'd1;
              if (r_cnt == 3'd1) w_state_nx = ST_WAIT;
            end
          end else if (!w_h.known) begin
            w_err_set  = 1'b1;
            w_state_nx = ST_SKIP;
          end else begin
            w_rx_v      = 1'b1;
            w_rx_first  = 1'b1;
            w_inonly_nx = w_h.in_only;
            w_cnt_nx    = w_h.len - 3'd1;
            if (!w_h.in_only && w_h.len == 3'd1)
              w_state_nx = ST_WAIT;
            else
              w_state_nx = ST_HDR;
          end
        end
        ST_WAIT: if (w_pos) begin
          if (!r_nib) w_nib_nx = 1'b1;
          else        w_launch = 1'b1;
        end
        ST_TX: if (w_pos) begin
          if (r_nib) begin
            w_out_nx = r_lo;
            w_nib_nx = 1'b0;
          end else begin
            w_launch = 1'b1;
          end
        end
        ST_SKIP: w_state_nx = ST_SKIP;
        default: w_state_nx = ST_IDLE;
      endcase
      // High-nibble launch: the posedge just seen was the host's sample.
      if (w_launch) begin
        w_state_nx = ST_TX;
        w_oe_nx    = 1'b1;
        w_nib_nx   = 1'b1;
        if (tx_valid) begin
          {w_out_nx, w_lo_nx} = tx_data;
          w_tx_rdy = 1'b1;
        end else begin
          {w_out_nx, w_lo_nx} = IDLE_BYTE;
          w_err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nib       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_inonly    <= 1'b0;
      r_oe        <= 1'b0;
      r_out       <= '0;
      r_armed     <= 1'b0;
      r_csb_prev  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_rx_data   <= '0;
      r_frame_end <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_nib       <= w_nib_nx;
      r_hi        <= w_hi_nx;
      r_lo        <= w_lo_nx;
      r_cnt       <= w_cnt_nx;
      r_inonly    <= w_inonly_nx;
      r_oe        <= w_oe_nx;
      r_out       <= w_out_nx;
      // A frame may only start once csb has been seen high.
      if (w_csb) r_armed <= 1'b1;
      r_csb_prev  <= w_csb;
      r_frame_end <= w_csb & ~r_csb_prev & r_armed;
      r_rx_valid  <= w_rx_v;
      r_rx_first  <= w_rx_first;
      if (w_rx_v) r_rx_data <= w_byte;
      r_tx_ready  <= w_tx_rdy;
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
    end
  end

  assign qpi_io_out = r_out;
  assign qpi_io_oe  = r_oe;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign rx_first   = r_rx_first;
  assign frame_end  = r_frame_end;
  assign tx_ready   = r_tx_ready;
  assign qpi_err    = r_err;

endmodule

// File: tb/tb_marlann_qpi_target.sv
// Directed bench for marlann_qpi_target: QPI host model plus rx
// scoreboard; QPI_GLITCH_FILTER_EN enables the glitched-clock frame.
module tb_marlann_qpi_target;

  localparam int HALF = 80;

  logic       clock = 1'b0;
  logic       reset;
  logic       qpi_csb, qpi_clk;
  logic [3:0] qpi_io_in, qpi_io_out;
  logic       qpi_io_oe;
  logic       rx_valid, rx_first, frame_end;
  logic [7:0] rx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       qpi_err, err_clear;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int txr_cnt = 0;
  int ecnt = 0;
  bit oe_seen = 1'b0;
  bit glitch_on = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       f;
  } exp_t;
  exp_t q[$];

  marlann_qpi_target dut (
    .clock      (clock),
    .reset      (reset),
    .qpi_csb    (qpi_csb),
    .qpi_clk    (qpi_clk),
    .qpi_io_in  (qpi_io_in),
    .qpi_io_out (qpi_io_out),
    .qpi_io_oe  (qpi_io_oe),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_first   (rx_first),
    .frame_end  (frame_end),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .qpi_err    (qpi_err),
    .err_clear  (err_clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic have;
    if (rx_valid) begin
      have = (q.size() > 0);
      e.d = 8'h00;
      e.f = 1'b0;
      if (have) e = q.pop_front();
      chk("rx_byte", 16'({1'b1, rx_first, rx_data}),
          16'({have, e.f, e.d}));
    end
    if (frame_end) fe_cnt++;
    if (tx_ready) txr_cnt++;
    if (qpi_io_oe) oe_seen = 1'b1;
  end

  task automatic push(input logic [7:0] d, input logic f);
    exp_t e;
    e.d = d;
    e.f = f;
    q.push_back(e);
  endtask

  task automatic half();
    ecnt++;
    if (glitch_on && (ecnt % 16 == 0)) begin
      #(HALF/2 + 4) qpi_clk = ~qpi_clk;
      #2 qpi_clk = ~qpi_clk;
      #(HALF/2 - 6);
    end else begin
      #HALF;
    end
  endtask

  task automatic nib(input logic [3:0] n);
    qpi_io_in = n;
    half();
    qpi_clk = 1'b1;
    half();
    qpi_clk = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic rbyte(output logic [7:0] b, input logic [7:0] nxt,
                       input bit last);
    #HALF qpi_clk = 1'b1;
    b[7:4] = qpi_io_out;
    #HALF qpi_clk = 1'b0;
    #HALF qpi_clk = 1'b1;
    b[3:0] = qpi_io_out;
    tx_data = nxt;
    if (last) qpi_csb = 1'b1;
    #HALF qpi_clk = 1'b0;
    if (last) #(2*HALF);
  endtask

  task automatic start();
    qpi_csb = 1'b0;
    #HALF;
  endtask

  task automatic stop();
    #HALF qpi_csb = 1'b1;
    #(2*HALF);
  endtask

  initial begin
    logic [7:0] b;
    int fe0, tr0;
    reset = 1'b1;
    qpi_csb = 1'b1;
    qpi_clk = 1'b0;
    qpi_io_in = 4'h0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    err_clear = 1'b0;
    #10;
    chk("rst_oe", 16'(qpi_io_oe), 16'd0);
    chk("rst_out", 16'(qpi_io_out), 16'd0);
    chk("rst_rxv", 16'(rx_valid), 16'd0);
    chk("rst_fe", 16'(frame_end), 16'd0);
    chk("rst_txr", 16'(tx_ready), 16'd0);
    chk("rst_err", 16'(qpi_err), 16'd0);
    #10 reset = 1'b0;
    #200;
    chk("startup_fe", 16'(fe_cnt), 16'd0);

    // in-only write frame
    push(8'h21, 1'b1); push(8'hA5, 1'b0); push(8'h3C, 1'b0);
    oe_seen = 1'b0;
    fe0 = fe_cnt;
    start(); wbyte(8'h21); wbyte(8'hA5); wbyte(8'h3C); stop();
    chk("t1_oe", 16'(oe_seen), 16'd0);
    chk("t1_fe", 16'(fe_cnt - fe0), 16'd1);
    chk("t1_q", 16'(q.size()), 16'd0);

    // 4-byte header, wait, read 2 bytes
    push(8'h23, 1'b1); push(8'h34, 1'b0);
    push(8'h12, 1'b0); push(8'h04, 1'b0);
    tx_valid = 1'b1;
    tx_data = 8'h07;
    tr0 = txr_cnt;
    start();
    wbyte(8'h23); wbyte(8'h34); wbyte(8'h12); wbyte(8'h04);
    wbyte(8'h00);
    chk("t2_oe", 16'(qpi_io_oe), 16'd1);
    rbyte(b, 8'h00, 1'b0);
    chk("t2_b0", 16'(b), 16'h07);
    rbyte(b, 8'h00, 1'b1);
    chk("t2_b1", 16'(b), 16'h00);
    chk("t2_txr", 16'(txr_cnt - tr0), 16'd2);
    chk("t2_oe_off", 16'(qpi_io_oe), 16'd0);
    chk("t2_err", 16'(qpi_err), 16'd0);
    chk("t2_q", 16'(q.size()), 16'd0);

    // underrun
    push(8'h22, 1'b1);
    tx_valid = 1'b0;
    tr0 = txr_cnt;
    start(); wbyte(8'h22); wbyte(8'h00);
    rbyte(b, 8'h00, 1'b1);
    chk("t3_b", 16'(b), 16'hFF);
    chk("t3_err", 16'(qpi_err), 16'd1);
    chk("t3_txr", 16'(txr_cnt - tr0), 16'd0);
    err_clear = 1'b1;
    #10 err_clear = 1'b0;
    #10;
    chk("t3_clr", 16'(qpi_err), 16'd0);

    // unknown command, then a good frame
    oe_seen = 1'b0;
    start(); wbyte(8'h5A); wbyte(8'h11); wbyte(8'h22); stop();
    chk("t4_err", 16'(qpi_err), 16'd1);
    chk("t4_oe", 16'(oe_seen), 16'd0);
    err_clear = 1'b1;
    #10 err_clear = 1'b0;
    #10;
    push(8'h20, 1'b1);
    start(); wbyte(8'h20); stop();
    chk("t4_q", 16'(q.size()), 16'd0);
    chk("t4_err2", 16'(qpi_err), 16'd0);

    // partial byte dropped by csb high
    push(8'h21, 1'b1);
    fe0 = fe_cnt;
    start(); wbyte(8'h21); nib(4'h9); stop();
    chk("t6_fe", 16'(fe_cnt - fe0), 16'd1);
    chk("t6_q", 16'(q.size()), 16'd0);

    // reset during TX
    push(8'h22, 1'b1);
    tx_valid = 1'b1;
    tx_data = 8'hC3;
    start(); wbyte(8'h22); wbyte(8'h00);
    #HALF qpi_clk = 1'b1;
    chk("t6_hi", 16'(qpi_io_out), 16'hC);
    #HALF qpi_clk = 1'b0;
    chk("t6_oe_pre", 16'(qpi_io_oe), 16'd1);
    #20 reset = 1'b1;
    #1;
    chk("t6_rst_oe", 16'(qpi_io_oe), 16'd0);
    chk("t6_rst_out", 16'(qpi_io_out), 16'd0);
    #19 reset = 1'b0;
    oe_seen = 1'b0;
    wbyte(8'h21); wbyte(8'h44); stop();
    chk("t6_ign_oe", 16'(oe_seen), 16'd0);
    chk("t6_ign_q", 16'(q.size()), 16'd0);
    push(8'h20, 1'b1);
    start(); wbyte(8'h20); stop();
    chk("t6_resume", 16'(q.size()), 16'd0);

`ifdef QPI_GLITCH_FILTER_EN
    push(8'h21, 1'b1); push(8'hA5, 1'b0); push(8'h3C, 1'b0);
    glitch_on = 1'b1;
    ecnt = 0;
    start(); wbyte(8'h21); wbyte(8'hA5); wbyte(8'h3C); stop();
    glitch_on = 1'b0;
    chk("t5_q", 16'(q.size()), 16'd0);
`endif

    #100;
    chk("final_q", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
